hive_rbus_arb: RTL and testbench
================================

Name: hive_rbus_arb

Overview:
- Round-robin arbiter and sequencer sharing one rbus register-set port among REQ_N requesters.
- Sits between the requesters (core, debug, DMA) and the OR-combined read data of the register sets.
- Issues single-cycle rd/wr strobes, tracks the fixed one-cycle read-data latency of the register sets, and routes captured read data back to the owning requester.

Parameters:
- REQ_N, 4, number of requesters (2..8)
- ADDR_W, 8, rbus address width (bits)
- DATA_W, 32, rbus data width (bits)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active low
- req_i  in  REQ_N  per-requester request level; held until ack
- req_wr_i  in  REQ_N  1=write, 0=read; valid while req high
- req_addr_i  in  REQ_N*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W]
- req_wr_data_i  in  REQ_N*DATA_W  packed write data, same packing
- ack_o  out  REQ_N  one-hot pulse; request accepted and strobe on bus this cycle
- rd_vld_o  out  REQ_N  one-hot pulse; rd_data_o valid for that requester
- rd_data_o  out  DATA_W  read data, shared by all requesters
- busy_o  out  1  FSM not in IDLE
- rbus_addr_o  out  ADDR_W  bus address
- rbus_wr_o  out  1  bus write strobe
- rbus_rd_o  out  1  bus read strobe
- rbus_wr_data_o  out  DATA_W  bus write data
- rbus_rd_data_i  in  DATA_W  OR-combined register read data; valid the cycle after rbus_rd_o

Behaviour:
- Reset: all outputs 0; FSM=IDLE; RR pointer=0.
- Reset mid-transaction abandons it: no ack_o, no rd_vld_o.
- All outputs are registered except busy_o, which is decoded from state.
- FSM states:
  - IDLE: if any req_i, select winner w, load rbus outputs and ack_o[w], go to BUS. Else hold.
  - BUS: rbus_wr_o or rbus_rd_o = 1 and ack_o[w] = 1 for exactly this cycle. Write -> IDLE; read -> RESP.
  - RESP: strobes 0; rbus_addr_o held. Capture rd_data_o <= rbus_rd_data_i, set rd_vld_o[w] for the next cycle, go to IDLE.
- rd_vld_o is a one-cycle pulse in the cycle after RESP, overlapping the following IDLE.
- Throughput: write every 2 cycles; read every 3 cycles. Read latency is 3 cycles from the IDLE sample to rd_vld_o.
- Arbitration:
  - Round-robin. Search starts at index ptr; first asserted req_i at or after ptr (wrapping modulo REQ_N) wins.
  - On grant, ptr <= (w+1) mod REQ_N.
  - Requests are sampled only in IDLE. Changes during BUS/RESP are ignored.
- Requester rules:
  - Hold req, wr, addr and data stable until ack_o.
  - req high in the cycle after ack_o is a new request. Back-to-back requests are legal by updating the fields that cycle.
  - Dropping req before ack is allowed; the request is withdrawn if not yet sampled.
- Bus data:
  - rbus_wr_data_o = winner data on writes, 0 on reads.
  - rbus_addr_o and rbus_wr_data_o hold their last value in IDLE (no toggling).
- Strobes are never both high. At most one bit of ack_o and one bit of rd_vld_o is high.
- A requester with an outstanding read may be re-granted only after its rd_vld_o. This is guaranteed by the single-outstanding FSM.

Test Plan:
- Single write: req_i=0001, wr=1, addr=0x12, data=0xDEADBEEF.
  -> rbus_wr_o=1, addr 0x12, wr_data 0xDEADBEEF, ack_o=0001 in the 2nd cycle after req; busy_o high 1 cycle.
- Single read: req_i[2], addr=0x05; bench drives rbus_rd_data_i=0xA5A5_0001 the cycle after rbus_rd_o.
  -> rd_vld_o=0100 and rd_data_o=0xA5A50001 exactly 2 cycles after rbus_rd_o; rbus_wr_data_o=0 during the read.
- All four requesting writes continuously from reset.
  -> grant order 0,1,2,3,0,1 with one grant every 2 cycles; ptr wraps 3->0.
- Simultaneous req_i=1010 after req 1 was just granted (ptr=2).
  -> 3 wins, then 1; never both strobes high.
- rst_n_i low during RESP of a read to requester 1.
  -> all outputs 0 immediately (async); no rd_vld_o after release; next req_i=0010 granted normally with ptr=0.
- Requester 0 drops req during BUS of requester 2's read.
  -> no ack_o[0]; after RESP, FSM idles with busy_o=0.

Source files
------------

// File: rtl/hive_rbus_arb.sv
// Round-robin arbiter and sequencer sharing one rbus register-set port among REQ_N requesters.
// Issues single-cycle rd/wr strobes and returns captured read data to the owning requester.
module hive_rbus_arb #(
    parameter int REQ_N  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [REQ_N-1:0]        req_i,
    input  logic [REQ_N-1:0]        req_wr_i,
    input  logic [REQ_N*ADDR_W-1:0] req_addr_i,
    input  logic [REQ_N*DATA_W-1:0] req_wr_data_i,
    output logic [REQ_N-1:0]        ack_o,
    output logic [REQ_N-1:0]        rd_vld_o,
    output logic [DATA_W-1:0]       rd_data_o,
    output logic                    busy_o,
    output logic [ADDR_W-1:0]       rbus_addr_o,
    output logic                    rbus_wr_o,
    output logic                    rbus_rd_o,
    output logic [DATA_W-1:0]       rbus_wr_data_o,
    input  logic [DATA_W-1:0]       rbus_rd_data_i
);

    localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam logic [PTR_W:0] REQ_N_W = (PTR_W + 1)'(REQ_N);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  ptr, ptr_nxt;
    logic [PTR_W-1:0]  gnt_idx, gnt_idx_nxt;
    logic              gnt_wr, gnt_wr_nxt;
    logic              found;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  win_inc;
    logic [PTR_W:0]    sum;

    logic [REQ_N-1:0]  ack_nxt, rd_vld_nxt;
    logic [DATA_W-1:0] rd_data_nxt, wr_data_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              wr_nxt, rd_nxt;

    logic [ADDR_W-1:0] addr_arr    [REQ_N];
    logic [DATA_W-1:0] wr_data_arr [REQ_N];

    for (genvar k = 0; k < REQ_N; k++) begin : g_unpack
        assign addr_arr[k]    = req_addr_i[k*ADDR_W +: ADDR_W];
        assign wr_data_arr[k] = req_wr_data_i[k*DATA_W +: DATA_W];
    end

    // Round-robin search: first asserted request at or after ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        sum     = '0;
        win_inc = '0;
        for (int i = 0; i < REQ_N; i++) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (sum >= REQ_N_W) sum = sum - REQ_N_W;
            if (!found && req_i[sum[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = sum[PTR_W-1:0];
            end
        end
        sum = {1'b0, win} + (PTR_W + 1)'(1);
        if (sum >= REQ_N_W) sum = sum - REQ_N_W;
        win_inc = sum[PTR_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (found) state_nxt = S_BUS;
            S_BUS:   state_nxt = gnt_wr ? S_IDLE : S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ack_nxt     = '0;
        rd_vld_nxt  = '0;
        wr_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        rd_data_nxt = rd_data_o;
        addr_nxt    = rbus_addr_o;
        wr_data_nxt = rbus_wr_data_o;
        gnt_idx_nxt = gnt_idx;
        gnt_wr_nxt  = gnt_wr;
        ptr_nxt     = ptr;
        unique case (state)
            S_IDLE: begin
                if (found) begin
                    ack_nxt[win] = 1'b1;
                    addr_nxt     = addr_arr[win];
                    wr_nxt       = req_wr_i[win];
                    rd_nxt       = !req_wr_i[win];
                    wr_data_nxt  = req_wr_i[win] ? wr_data_arr[win] : '0;
                    gnt_idx_nxt  = win;
                    gnt_wr_nxt   = req_wr_i[win];
                    ptr_nxt      = win_inc;
                end
            end
            S_RESP: begin
                rd_data_nxt         = rbus_rd_data_i;
                rd_vld_nxt[gnt_idx] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_o          <= '0;
            rd_vld_o       <= '0;
            rd_data_o      <= '0;
            rbus_addr_o    <= '0;
            rbus_wr_o      <= 1'b0;
            rbus_rd_o      <= 1'b0;
            rbus_wr_data_o <= '0;
            gnt_idx        <= '0;
            gnt_wr         <= 1'b0;
            ptr            <= '0;
        end else begin
            ack_o          <= ack_nxt;
            rd_vld_o       <= rd_vld_nxt;
            rd_data_o      <= rd_data_nxt;
            rbus_addr_o    <= addr_nxt;
            rbus_wr_o      <= wr_nxt;
            rbus_rd_o      <= rd_nxt;
            rbus_wr_data_o <= wr_data_nxt;
            gnt_idx        <= gnt_idx_nxt;
            gnt_wr         <= gnt_wr_nxt;
            ptr            <= ptr_nxt;
        end
    end

    assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_hive_rbus_arb.sv
// Directed bench for hive_rbus_arb: writes, reads, round-robin order, mid-read reset, withdrawn request.
module tb_hive_rbus_arb;

    localparam int REQ_N  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic                    clk_i = 1'b0;
    logic                    rst_n_i;
    logic [REQ_N-1:0]        req_i;
    logic [REQ_N-1:0]        req_wr_i;
    logic [REQ_N*ADDR_W-1:0] req_addr_i;
    logic [REQ_N*DATA_W-1:0] req_wr_data_i;
    logic [REQ_N-1:0]        ack_o;
    logic [REQ_N-1:0]        rd_vld_o;
    logic [DATA_W-1:0]       rd_data_o;
    logic                    busy_o;
    logic [ADDR_W-1:0]       rbus_addr_o;
    logic                    rbus_wr_o;
    logic                    rbus_rd_o;
    logic [DATA_W-1:0]       rbus_wr_data_o;
    logic [DATA_W-1:0]       rbus_rd_data_i;

    int total = 0;
    int bad   = 0;

    hive_rbus_arb #(.REQ_N(REQ_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .req_i          (req_i),
        .req_wr_i       (req_wr_i),
        .req_addr_i     (req_addr_i),
        .req_wr_data_i  (req_wr_data_i),
        .ack_o          (ack_o),
        .rd_vld_o       (rd_vld_o),
        .rd_data_o      (rd_data_o),
        .busy_o         (busy_o),
        .rbus_addr_o    (rbus_addr_o),
        .rbus_wr_o      (rbus_wr_o),
        .rbus_rd_o      (rbus_rd_o),
        .rbus_wr_data_o (rbus_wr_data_o),
        .rbus_rd_data_i (rbus_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ack"},    64'(ack_o), 0);
        check({tag, ".rdvld"},  64'(rd_vld_o), 0);
        check({tag, ".rddata"}, 64'(rd_data_o), 0);
        check({tag, ".busy"},   64'(busy_o), 0);
        check({tag, ".addr"},   64'(rbus_addr_o), 0);
        check({tag, ".wr"},     64'(rbus_wr_o), 0);
        check({tag, ".rd"},     64'(rbus_rd_o), 0);
        check({tag, ".wdata"},  64'(rbus_wr_data_o), 0);
    endtask

    // Bus-wide invariants sampled every cycle away from the active edge.
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            check("strobe_excl", 64'(rbus_wr_o & rbus_rd_o), 0);
            check("ack_onehot",  64'($countones(ack_o) <= 1), 1);
            check("vld_onehot",  64'($countones(rd_vld_o) <= 1), 1);
        end
    end

    initial begin
        rst_n_i        = 1'b0;
        req_i          = '0;
        req_wr_i       = '0;
        req_addr_i     = '0;
        req_wr_data_i  = '0;
        rbus_rd_data_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        rst_n_i = 1'b1;
        step();
        check_all_zero("post_reset");

        // Single write from requester 0.
        req_i = 4'b0001; req_wr_i = 4'b0001;
        req_addr_i[0 +: 8] = 8'h12; req_wr_data_i[0 +: 32] = 32'hDEADBEEF;
        step();
        check("wr.ack",   64'(ack_o), 4'b0001);
        check("wr.strb",  64'(rbus_wr_o), 1);
        check("wr.rd",    64'(rbus_rd_o), 0);
        check("wr.addr",  64'(rbus_addr_o), 8'h12);
        check("wr.wdata", 64'(rbus_wr_data_o), 32'hDEADBEEF);
        check("wr.busy",  64'(busy_o), 1);
        req_i = '0;
        step();
        check("wr.idle_busy", 64'(busy_o), 0);
        check("wr.idle_strb", 64'(rbus_wr_o), 0);
        check("wr.idle_ack",  64'(ack_o), 0);
        check("wr.hold_addr", 64'(rbus_addr_o), 8'h12);
        check("wr.hold_data", 64'(rbus_wr_data_o), 32'hDEADBEEF);

        // Single read from requester 2; read data returned the cycle after the strobe.
        req_i = 4'b0100; req_wr_i = 4'b0000; req_addr_i[16 +: 8] = 8'h05;
        step();
        check("rd.ack",   64'(ack_o), 4'b0100);
        check("rd.strb",  64'(rbus_rd_o), 1);
        check("rd.wr",    64'(rbus_wr_o), 0);
        check("rd.addr",  64'(rbus_addr_o), 8'h05);
        check("rd.wdata", 64'(rbus_wr_data_o), 0);
        req_i = '0; rbus_rd_data_i = 32'hA5A5_0001;
        step();
        check("rd.resp_strb", 64'(rbus_rd_o), 0);
        check("rd.resp_ack",  64'(ack_o), 0);
        check("rd.resp_busy", 64'(busy_o), 1);
        check("rd.resp_addr", 64'(rbus_addr_o), 8'h05);
        check("rd.resp_vld",  64'(rd_vld_o), 0);
        step();
        check("rd.vld",   64'(rd_vld_o), 4'b0100);
        check("rd.data",  64'(rd_data_o), 32'hA5A50001);
        check("rd.busy",  64'(busy_o), 0);
        rbus_rd_data_i = '0;
        step();
        check("rd.vld_pulse", 64'(rd_vld_o), 0);

        // Fresh reset, then all four requesters writing continuously.
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        req_i = 4'b1111; req_wr_i = 4'b1111;
        for (int k = 0; k < REQ_N; k++) begin
            req_addr_i[k*8 +: 8]     = 8'(8'h10 + k);
            req_wr_data_i[k*32 +: 32] = 32'(32'h100 + k);
        end
        for (int g = 0; g < 6; g++) begin
            step();
            check($sformatf("rr.ack%0d", g),  64'(ack_o), 64'(1 << (g % 4)));
            check($sformatf("rr.addr%0d", g), 64'(rbus_addr_o), 64'(8'h10 + (g % 4)));
            check($sformatf("rr.wr%0d", g),   64'(rbus_wr_o), 1);
            step();
            check($sformatf("rr.gap%0d", g),  64'(ack_o), 0);
            check($sformatf("rr.idle%0d", g), 64'(busy_o), 0);
        end

        // Requester 1 just granted, so ptr=2: requester 3 wins before 1.
        req_i = 4'b1010;
        step();
        check("sim.first",  64'(ack_o), 4'b1000);
        check("sim.addr1",  64'(rbus_addr_o), 8'h13);
        step();
        step();
        check("sim.second", 64'(ack_o), 4'b0010);
        check("sim.addr2",  64'(rbus_addr_o), 8'h11);
        req_i = '0;
        step();

        // Reset asserted mid-read (RESP) to requester 1.
        req_i = 4'b0010; req_wr_i = 4'b0000; req_addr_i[8 +: 8] = 8'h33;
        step();
        check("rst.ack", 64'(ack_o), 4'b0010);
        req_i = '0; rbus_rd_data_i = 32'h1234_5678;
        step();
        check("rst.in_resp", 64'(busy_o), 1);
        #2 rst_n_i = 1'b0;
        #1 check_all_zero("rst.async");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        rbus_rd_data_i = '0;
        step();
        check("rst.no_vld1", 64'(rd_vld_o), 0);
        step();
        check("rst.no_vld2", 64'(rd_vld_o), 0);
        check("rst.rddata",  64'(rd_data_o), 0);
        // ptr back at 0: with requesters 1 and 2 asking, 1 wins.
        req_i = 4'b0110; req_wr_i = 4'b0110;
        step();
        check("rst.regrant", 64'(ack_o), 4'b0010);
        req_i = '0;
        step();

        // Requester 0 withdraws during requester 2's read (ptr=2 so 2 wins).
        req_i = 4'b0101; req_wr_i = 4'b0001; req_addr_i[16 +: 8] = 8'h44;
        step();
        check("wd.ack",  64'(ack_o), 4'b0100);
        check("wd.rd",   64'(rbus_rd_o), 1);
        req_i = '0; rbus_rd_data_i = 32'hCAFE_0002;
        step();
        check("wd.resp_ack", 64'(ack_o), 0);
        step();
        check("wd.vld",   64'(rd_vld_o), 4'b0100);
        check("wd.data",  64'(rd_data_o), 32'hCAFE0002);
        check("wd.busy",  64'(busy_o), 0);
        rbus_rd_data_i = '0;
        step();
        check("wd.no_ack0", 64'(ack_o), 0);
        check("wd.idle",    64'(busy_o), 0);
        step();
        check("wd.no_ack0b", 64'(ack_o), 0);
        check("wd.idle_b",   64'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
